// File: rtl/sa_w_channel.sv
// Slave-side W-channel arbiter: forwards master W bursts in AW-grant order through a full skid stage.
// Optional SA_W_ORDER_BYPASS_EN lets a grant pushed into an empty order FIFO select its master that same cycle.
module sa_w_channel #(
   parameter int unsigned MST_AMT    = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MST_ID_W   = $clog2(MST_AMT),
   parameter int unsigned OST_DEPTH  = 4
) (
   input  logic                          ACLK_i,
   input  logic                          ARESET_i,
   input  logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i,
   input  logic [MST_AMT-1:0]            dsp_WLAST_i,
   input  logic [MST_AMT-1:0]            dsp_WVALID_i,
   output logic [MST_AMT-1:0]            dsp_WREADY_o,
   input  logic [MST_ID_W-1:0]           sa_AW_mst_id_i,
   input  logic                          sa_AW_push_i,
   output logic                          sa_AW_push_ready_o,
   output logic [DATA_WIDTH-1:0]         s_WDATA_o,
   output logic                          s_WLAST_o,
   output logic                          s_WVALID_o,
   input  logic                          s_WREADY_i,
   output logic [$clog2(OST_DEPTH):0]    ost_cnt_o
);
   localparam int unsigned PTR_W = $clog2(OST_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [MST_ID_W-1:0]   id_mem [OST_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      cnt;
   logic                  full;
   logic                  empty;
   logic                  bypass;
   logic                  head_valid;
   logic [MST_ID_W-1:0]   sel;
   logic [DATA_WIDTH-1:0] beat_data;
   logic                  beat_last;
   logic                  beat_valid;
   logic                  accept;
   logic                  pop_req;
   logic                  do_push;
   logic                  do_pop;
   logic                  skid_in_ready;
   logic                  sk_valid;
   logic [DATA_WIDTH-1:0] sk_data;
   logic                  sk_last;
   logic                  sk_load;
   logic                  sk_drain;

   assign empty              = (cnt == '0);
   assign full               = (cnt == CNT_W'(OST_DEPTH));
   assign sa_AW_push_ready_o = ~full;
   assign ost_cnt_o          = cnt;

`ifdef SA_W_ORDER_BYPASS_EN
   assign bypass = empty & sa_AW_push_i;
`else
   assign bypass = 1'b0;
`endif

   assign head_valid = ~empty | bypass;
   assign sel        = bypass ? sa_AW_mst_id_i : id_mem[rd_ptr];

   // Route the selected master's beat and grant WREADY only to it
   always_comb begin
      dsp_WREADY_o = '0;
      beat_data    = '0;
      beat_last    = 1'b0;
      beat_valid   = 1'b0;
      for (int unsigned m = 0; m < MST_AMT; m++) begin
         if (sel == MST_ID_W'(m)) begin
            dsp_WREADY_o[m] = head_valid & skid_in_ready;
            beat_data       = dsp_WDATA_i[DATA_WIDTH*m +: DATA_WIDTH];
            beat_last       = dsp_WLAST_i[m];
            beat_valid      = dsp_WVALID_i[m];
         end
      end
   end

   assign accept  = beat_valid & head_valid & skid_in_ready;
   assign pop_req = accept & beat_last;
   // A bypassed single-beat burst completes without ever occupying the FIFO
   assign do_push = sa_AW_push_i & ~full & ~(bypass & pop_req);
   assign do_pop  = pop_req & ~bypass;

   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int unsigned i = 0; i < OST_DEPTH; i++) id_mem[i] <= '0;
      end else begin
         if (do_push) begin
            id_mem[wr_ptr] <= sa_AW_mst_id_i;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign sk_load  = accept & s_WVALID_o & ~s_WREADY_i;
   assign sk_drain = ~accept & s_WVALID_o & s_WREADY_i & sk_valid;

   // Output register plus one skid entry; input ready is the registered "skid will be empty"
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         s_WVALID_o    <= 1'b0;
         s_WDATA_o     <= '0;
         s_WLAST_o     <= 1'b0;
         sk_valid      <= 1'b0;
         sk_data       <= '0;
         sk_last       <= 1'b0;
         skid_in_ready <= 1'b0;
      end else begin
         skid_in_ready <= ~(sk_load | (sk_valid & ~sk_drain));
         if (accept) begin
            if (sk_load) begin
               sk_valid <= 1'b1;
               sk_data  <= beat_data;
               sk_last  <= beat_last;
            end else begin
               s_WVALID_o <= 1'b1;
               s_WDATA_o  <= beat_data;
               s_WLAST_o  <= beat_last;
            end
         end else if (s_WVALID_o && s_WREADY_i) begin
            if (sk_valid) begin
               s_WDATA_o <= sk_data;
               s_WLAST_o <= sk_last;
               sk_valid  <= 1'b0;
            end else begin
               s_WVALID_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sa_w_channel.sv
// Directed bench for sa_w_channel: ordering, backpressure, full FIFO, empty FIFO, throughput, async reset.
module tb_sa_w_channel;
   logic        clk = 1'b0;
   logic        ARESET_i;
   logic [63:0] dsp_WDATA_i;
   logic [1:0]  dsp_WLAST_i;
   logic [1:0]  dsp_WVALID_i;
   logic [1:0]  dsp_WREADY_o;
   logic [0:0]  sa_AW_mst_id_i;
   logic        sa_AW_push_i;
   logic        sa_AW_push_ready_o;
   logic [31:0] s_WDATA_o;
   logic        s_WLAST_o;
   logic        s_WVALID_o;
   logic        s_WREADY_i;
   logic [2:0]  ost_cnt_o;

   sa_w_channel dut (
      .ACLK_i(clk), .ARESET_i(ARESET_i),
      .dsp_WDATA_i(dsp_WDATA_i), .dsp_WLAST_i(dsp_WLAST_i),
      .dsp_WVALID_i(dsp_WVALID_i), .dsp_WREADY_o(dsp_WREADY_o),
      .sa_AW_mst_id_i(sa_AW_mst_id_i), .sa_AW_push_i(sa_AW_push_i),
      .sa_AW_push_ready_o(sa_AW_push_ready_o),
      .s_WDATA_o(s_WDATA_o), .s_WLAST_o(s_WLAST_o), .s_WVALID_o(s_WVALID_o),
      .s_WREADY_i(s_WREADY_i), .ost_cnt_o(ost_cnt_o)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [32:0] mq0 [$];
   logic [32:0] mq1 [$];
   logic [32:0] got_q [$];
   logic [1:0]  acc_pend = 2'b00;
   logic        prev_stall = 1'b0;
   logic [32:0] prev_beat = '0;
   logic        byp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Masters present the head of their beat queue
   task automatic drive_dsp();
      logic [32:0] b0, b1;
      b0 = (mq0.size() > 0) ? mq0[0] : 33'h0;
      b1 = (mq1.size() > 0) ? mq1[0] : 33'h0;
      dsp_WVALID_i = {mq1.size() > 0, mq0.size() > 0};
      dsp_WLAST_i  = {b1[32], b0[32]};
      dsp_WDATA_i  = {b1[31:0], b0[31:0]};
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Handshakes are decided by values stable between negedge and the next posedge
   always @(negedge clk) begin
      acc_pend = dsp_WVALID_i & dsp_WREADY_o;
      if (ARESET_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("stall_hold", {s_WVALID_o, s_WLAST_o, s_WDATA_o}, {1'b1, prev_beat});
         if (s_WVALID_o && s_WREADY_i) got_q.push_back({s_WLAST_o, s_WDATA_o});
         prev_stall = s_WVALID_o && !s_WREADY_i;
         prev_beat  = {s_WLAST_o, s_WDATA_o};
      end
   end

   always @(posedge clk) begin
      #1;
      if (acc_pend[0] && mq0.size() > 0) void'(mq0.pop_front());
      if (acc_pend[1] && mq1.size() > 0) void'(mq1.pop_front());
      acc_pend = 2'b00;
      drive_dsp();
   end

   initial begin
`ifdef SA_W_ORDER_BYPASS_EN
      byp = 1'b1;
`else
      byp = 1'b0;
`endif
      ARESET_i = 1'b1; sa_AW_push_i = 1'b0; sa_AW_mst_id_i = '0; s_WREADY_i = 1'b1;
      drive_dsp();
      cyc(2);
      check("rst_valid", s_WVALID_o, 0);
      check("rst_data", s_WDATA_o, 0);
      check("rst_last", s_WLAST_o, 0);
      check("rst_wready", dsp_WREADY_o, 0);
      check("rst_push_ready", sa_AW_push_ready_o, 1);
      check("rst_ost", ost_cnt_o, 0);
      ARESET_i = 1'b0;

      // Ordering: grant master1 then master0
      for (int i = 0; i < 4; i++) begin
         mq0.push_back({i == 3, 32'hA0 + 32'(i)});
         mq1.push_back({i == 3, 32'hB0 + 32'(i)});
      end
      drive_dsp();
      got_q.delete();
      sa_AW_push_i = 1'b1; sa_AW_mst_id_i = 1'b1;
      cyc(1);
      sa_AW_mst_id_i = 1'b0;
      cyc(1);
      sa_AW_push_i = 1'b0;
      check("ord_ost2", ost_cnt_o, 2);
      cyc(3);
      check("ord_ost1", ost_cnt_o, 1);
      cyc(4);
      check("ord_ost0", ost_cnt_o, 0);
      cyc(2);
      check("ord_count", got_q.size(), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
         check($sformatf("ord_beat%0d", i), got_q[i],
               {i == 3 || i == 7, (i < 4) ? 32'hB0 + 32'(i) : 32'hA0 + 32'(i - 4)});

      // Backpressure: sustained stall then toggling ready
      got_q.delete();
      s_WREADY_i = 1'b0;
      for (int i = 0; i < 8; i++) mq1.push_back({i == 7, 32'hC0 + 32'(i)});
      drive_dsp();
      sa_AW_push_i = 1'b1; sa_AW_mst_id_i = 1'b1;
      cyc(1);
      sa_AW_push_i = 1'b0;
      cyc(2);
      check("bp_wready_drop", dsp_WREADY_o, 0);
      check("bp_head", {s_WVALID_o, s_WDATA_o}, {1'b1, 32'hC0});
      for (int k = 0; k < 60 && got_q.size() < 8; k++) begin
         s_WREADY_i = ~s_WREADY_i;
         cyc(1);
      end
      check("bp_count", got_q.size(), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
         check($sformatf("bp_beat%0d", i), got_q[i], {i == 7, 32'hC0 + 32'(i)});
      check("bp_ost0", ost_cnt_o, 0);

      // Full FIFO: four grants, refused fifth, refused push alongside a pop
      got_q.delete();
      s_WREADY_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sa_AW_push_i = 1'b1; sa_AW_mst_id_i = i[0];
         cyc(1);
      end
      sa_AW_mst_id_i = 1'b1;
      check("full_ost4", ost_cnt_o, 4);
      check("full_ready0", sa_AW_push_ready_o, 0);
      cyc(1);
      check("full_refused", ost_cnt_o, 4);
      mq0.push_back({1'b1, 32'hD0});
      drive_dsp();
      cyc(1);
      sa_AW_push_i = 1'b0;
      check("full_pushpop_ost", ost_cnt_o, 3);
      check("full_ready1", sa_AW_push_ready_o, 1);
      mq1.push_back({1'b1, 32'hE1});
      mq0.push_back({1'b1, 32'hE2});
      mq1.push_back({1'b1, 32'hE3});
      drive_dsp();
      for (int k = 0; k < 30 && got_q.size() < 4; k++) cyc(1);
      check("full_drain_ost", ost_cnt_o, 0);
      check("full_count", got_q.size(), 4);
      if (got_q.size() == 4) begin
         check("full_b0", got_q[0], {1'b1, 32'hD0});
         check("full_b1", got_q[1], {1'b1, 32'hE1});
         check("full_b2", got_q[2], {1'b1, 32'hE2});
         check("full_b3", got_q[3], {1'b1, 32'hE3});
      end

      // Empty FIFO with a waiting master
      got_q.delete();
      mq0.push_back({1'b1, 32'hF0});
      drive_dsp();
      cyc(3);
      check("empty_wready", dsp_WREADY_o, 0);
      check("empty_valid", s_WVALID_o, 0);
      check("empty_ost", ost_cnt_o, 0);
      sa_AW_push_i = 1'b1; sa_AW_mst_id_i = 1'b0;
      cyc(1);
      sa_AW_push_i = 1'b0;
      check("lat_valid_p1", s_WVALID_o, byp ? 1 : 0);
      check("lat_ost_p1", ost_cnt_o, byp ? 0 : 1);
      cyc(1);
      check("lat_valid_p2", s_WVALID_o, byp ? 0 : 1);
      cyc(2);
      check("lat_count", got_q.size(), 1);
      if (got_q.size() == 1) check("lat_beat", got_q[0], {1'b1, 32'hF0});

      // Throughput: pre-filled FIFO, alternating single-beat bursts
      for (int i = 0; i < 4; i++) begin
         sa_AW_push_i = 1'b1; sa_AW_mst_id_i = i[0];
         cyc(1);
      end
      sa_AW_push_i = 1'b0;
      check("tp_ost4", ost_cnt_o, 4);
      mq0.push_back({1'b1, 32'h60}); mq1.push_back({1'b1, 32'h61});
      mq0.push_back({1'b1, 32'h62}); mq1.push_back({1'b1, 32'h63});
      drive_dsp();
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         check($sformatf("tp_beat%0d", i), {s_WVALID_o, s_WLAST_o, s_WDATA_o},
               {1'b1, 1'b1, 32'h60 + 32'(i)});
      end
      check("tp_ost0", ost_cnt_o, 0);
      cyc(2);

      // Asynchronous reset mid-burst with beats buffered
      s_WREADY_i = 1'b0;
      for (int i = 0; i < 4; i++) mq1.push_back({i == 3, 32'h90 + 32'(i)});
      drive_dsp();
      sa_AW_push_i = 1'b1; sa_AW_mst_id_i = 1'b1;
      cyc(1);
      sa_AW_push_i = 1'b0;
      cyc(3);
      check("pre_rst_valid", s_WVALID_o, 1);
      ARESET_i = 1'b1;
      #1;
      check("arst_valid", s_WVALID_o, 0);
      check("arst_data", s_WDATA_o, 0);
      check("arst_last", s_WLAST_o, 0);
      check("arst_wready", dsp_WREADY_o, 0);
      check("arst_ost", ost_cnt_o, 0);
      check("arst_push_ready", sa_AW_push_ready_o, 1);
      mq0.delete(); mq1.delete();
      drive_dsp();
      cyc(2);
      ARESET_i = 1'b0;
      s_WREADY_i = 1'b1;
      cyc(2);
      check("post_rst_valid", s_WVALID_o, 0);
      check("post_rst_ost", ost_cnt_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sa_w_channel.md
Name: sa_W_channel

Overview:
- Slave-side write-data arbitration stage, one instance per slave port of the interconnect.
- Consumes the per-slave W outputs of every master's W-channel dispatcher and merges them onto one slave W interface.
- Beats are forwarded strictly in the order the slave's AW arbiter granted write addresses.
- Keeps a small in-order FIFO of granted master IDs; the head entry selects which master's W burst is forwarded; the entry is popped on the WLAST handshake.
- Output passes through a registered full skid stage.

Parameters:
- MST_AMT, 2, number of masters (dispatchers) feeding this slave.
- DATA_WIDTH, 32, W data width.
- MST_ID_W, $clog2(MST_AMT), width of a master index.
- OST_DEPTH, 4, max outstanding granted write bursts (order FIFO depth, power of 2, >=2).

Ports:
- ACLK_i  input  1  clock.
- ARESET_i  input  1  reset.
- dsp_WDATA_i  input  DATA_WIDTH*MST_AMT  W data per master; master m at [DATA_WIDTH*(m+1)-1 -: DATA_WIDTH].
- dsp_WLAST_i  input  MST_AMT  WLAST per master.
- dsp_WVALID_i  input  MST_AMT  WVALID per master.
- dsp_WREADY_o  output  MST_AMT  WREADY per master.
- sa_AW_mst_id_i  input  MST_ID_W  master index of the AW just granted.
- sa_AW_push_i  input  1  AW grant accepted by the slave this cycle; push the ID.
- sa_AW_push_ready_o  output  1  order FIFO can accept a push (AW arbiter must stall when low).
- s_WDATA_o  output  DATA_WIDTH  W data to slave.
- s_WLAST_o  output  1  WLAST to slave.
- s_WVALID_o  output  1  WVALID to slave.
- s_WREADY_i  input  1  WREADY from slave.
- ost_cnt_o  output  $clog2(OST_DEPTH)+1  current number of order FIFO entries.

Behaviour:
- Interface: one clock, ACLK_i. Reset ARESET_i is asynchronous and active-high.
- Reset: FIFO empty; ost_cnt_o=0; sa_AW_push_ready_o=1; s_WVALID_o=0; s_WDATA_o=0; s_WLAST_o=0; dsp_WREADY_o=0. Reset mid-burst discards all FIFO entries and buffered beats.
- Order FIFO:
  - Push when sa_AW_push_i & sa_AW_push_ready_o.
  - sa_AW_push_ready_o = ~full. The ready is registered-state based and does not account for a same-cycle pop, so a push while full is refused even if a pop occurs that cycle.
  - A push while not full and a pop in the same cycle are both performed; the count is unchanged.
  - Read/write pointers wrap modulo OST_DEPTH.
- Selection: head valid iff FIFO not empty; sel = head ID.
- Input handshake:
  - dsp_WREADY_o[m] = head_valid & (m==sel) & skid_in_ready.
  - All other bits of dsp_WREADY_o are 0.
  - Accept = dsp_WVALID_i[sel] & dsp_WREADY_o[sel]. WVALID from non-selected masters is ignored.
- Pop: on an accept with dsp_WLAST_i[sel]=1. The next burst's master is selected from the following cycle.
- Output skid (2-entry full skid buffer):
  - Accepted beat {WDATA, WLAST} appears on s_*_o the next cycle (latency 1).
  - skid_in_ready is a registered signal.
  - Sustains 1 beat/cycle while s_WREADY_i=1.
  - Output holds stable while s_WVALID_o=1 & s_WREADY_i=0.
- Empty FIFO: no WREADY asserted; beats queued in the skid stage still drain to the slave.
- A burst's beats are never interleaved with another master's beats.
- ost_cnt_o range: 0..OST_DEPTH.

Optional Feature:
- Macro: SA_W_ORDER_BYPASS_EN.
- Defined: when the FIFO is empty and sa_AW_push_i=1, sel = sa_AW_mst_id_i combinationally and head_valid=1 that cycle.
  - If that master's WLAST beat is accepted in the same cycle, the ID is not written (push and pop cancel; count stays 0).
  - Otherwise the ID is written normally.
- Undefined: a pushed ID becomes usable the cycle after the push (1-cycle bubble).

Test Plan:
- Reset: assert ARESET_i asynchronously mid-burst -> all outputs at reset values immediately; ost_cnt_o=0.
- Ordering: push IDs 1,0; master0 and master1 both present 4-beat bursts (data 0xA0.., 0xB0..) -> slave sees master1's 4 beats then master0's 4 beats, WLAST on beats 4 and 8; ost_cnt_o goes 2->1->0.
- Backpressure: s_WREADY_i toggles 1/0 every cycle during an 8-beat burst -> no beat lost or duplicated; data is stable while stalled; dsp_WREADY_o drops within 2 beats of sustained stall.
- Full FIFO: push 4 IDs with no W traffic -> sa_AW_push_ready_o=0, ost_cnt_o=4; a 5th push is refused; push and WLAST pop in the same cycle while full -> push refused, count 3.
- Empty with WVALID: master0 WVALID=1 and no grant -> dsp_WREADY_o=0 and s_WVALID_o=0 indefinitely; push ID 0 -> first beat on s_W 2 cycles after push without bypass, 1 cycle with SA_W_ORDER_BYPASS_EN.
- Throughput: back-to-back single-beat bursts from alternating masters with s_WREADY_i=1 -> 1 beat/cycle with bypass disabled and FIFO pre-filled.
